// File: rtl/mem_access_unit.sv
// Load/store front end for the operational-memory data port.
// Byte/halfword/word requests arrive on a valid/ready handshake and are
// turned into word-wide memory cycles. Sub-word stores are handled as a
// read-modify-write because the memory has no byte enables.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_misaligned,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   memAccessAddress,
    output logic                    memAccessWren,
    output logic [DATA_WIDTH-1:0]   memAccessData,
    output logic                    memAccessRden,
    input  logic [DATA_WIDTH-1:0]   memAccessOutput
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} stateT;

    stateT                  state;
    stateT                  nextState;
    logic                   writeReg;
    logic [1:0]             sizeReg;
    logic                   signedReg;
    logic [ADDR_WIDTH+1:0]  addrReg;
    logic [DATA_WIDTH-1:0]  wdataReg;
    logic [DATA_WIDTH-1:0]  mergeReg;
    logic                   errReg;
    logic [DATA_WIDTH-1:0]  rdataReg;
    logic                   accept;
    logic                   reqMisaligned;

    // Half on an odd byte, word off a word boundary, or the reserved size code.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed byte/half out of a little-endian word and extend it.
    function automatic logic [DATA_WIDTH-1:0] extendLoad(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [1:0] size,
                                                         input logic sgn,
                                                         input logic [1:0] lane);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'b0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay the low byte/half of the store data onto the word read back.
    function automatic logic [DATA_WIDTH-1:0] mergeStore(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [DATA_WIDTH-1:0] wdata,
                                                         input logic [1:0] size,
                                                         input logic [1:0] lane);
        logic [DATA_WIDTH-1:0] res;
        res = word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    assign accept        = (state == IDLE) && req_valid;
    assign reqMisaligned = isMisaligned(req_size, req_addr[1:0]);

    // Control state plus everything that drives an output: cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            writeReg <= 1'b0;
            sizeReg  <= 2'b00;
            addrReg  <= '0;
            errReg   <= 1'b0;
            rdataReg <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                writeReg <= req_write;
                sizeReg  <= req_size;
                addrReg  <= req_addr;
                errReg   <= reqMisaligned;
                if (reqMisaligned) begin
                    rdataReg <= '0;
                end
            end
            if (state == WAIT && !writeReg) begin
                rdataReg <= extendLoad(memAccessOutput, sizeReg, signedReg, addrReg[1:0]);
            end
            if (state == WRITE) begin
                rdataReg <= '0;
            end
        end
    end

    // Request payload and merged store word; only observed in states reset leaves.
    always_ff @(posedge clk) begin
        if (accept) begin
            signedReg <= req_signed;
            wdataReg  <= req_wdata;
        end
        if (state == WAIT && writeReg) begin
            mergeReg <= mergeStore(memAccessOutput, wdataReg, sizeReg, addrReg[1:0]);
        end
    end

    // Next-state decode; strobes come from the state alone so reset drops them at once.
    always_comb begin
        nextState     = state;
        memAccessRden = 1'b0;
        memAccessWren = 1'b0;
        memAccessData = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (reqMisaligned) begin
                        nextState = RESP;
                    end else if (req_write && req_size == 2'b10) begin
                        nextState = WRITE;
                    end else begin
                        nextState = READ;
                    end
                end
            end
            READ: begin
                memAccessRden = 1'b1;
                nextState     = WAIT;
            end
            WAIT: begin
                nextState = writeReg ? WRITE : RESP;
            end
            WRITE: begin
                memAccessWren = 1'b1;
                memAccessData = (sizeReg == 2'b10) ? wdataReg : mergeReg;
                nextState     = RESP;
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign req_ready        = (state == IDLE) && rst_n;
    assign busy             = (state != IDLE);
    assign resp_valid       = (state == RESP);
    assign resp_misaligned  = (state == RESP) && errReg;
    assign resp_rdata       = rdataReg;
    assign memAccessAddress = addrReg[ADDR_WIDTH+1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural word memory, directed requests,
// per-cycle strobe checks and a response scoreboard drained by a monitor.
module tb_mem_access_unit;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_misaligned;
    logic          busy;
    logic [AW-1:0] memAccessAddress;
    logic          memAccessWren;
    logic [31:0]   memAccessData;
    logic          memAccessRden;
    logic [31:0]   memAccessOutput;

    mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_misaligned  (resp_misaligned),
        .busy             (busy),
        .memAccessAddress (memAccessAddress),
        .memAccessWren    (memAccessWren),
        .memAccessData    (memAccessData),
        .memAccessRden    (memAccessRden),
        .memAccessOutput  (memAccessOutput)
    );

    always #5 clk = ~clk;

    // Memory model: read data one cycle after Rden; bench preload port when idle.
    logic [31:0] mem [0:255];
    logic        tbWr = 1'b0;
    logic [7:0]  tbAddr = 8'h00;
    logic [31:0] tbData = 32'h0;
    always @(posedge clk) begin
        if (memAccessRden) memAccessOutput <= mem[memAccessAddress[7:0]];
        if (memAccessWren) mem[memAccessAddress[7:0]] <= memAccessData;
        else if (tbWr)     mem[tbAddr] <= tbData;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } respT;
    respT expQ[$];

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (expQ.size() == 0) begin
                check("resp_unexpected", {31'b0, resp_valid}, 32'h0);
            end else begin
                respT e;
                e = expQ.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_misaligned", {31'b0, resp_misaligned}, {31'b0, e.mis});
            end
        end
    end

    // Accept bookkeeping for the back-to-back handshake checks.
    int cycle = 0;
    int acceptCnt = 0;
    int lastAcc = 0;
    int prevAcc = 0;
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst_n && req_valid && req_ready) begin
            acceptCnt <= acceptCnt + 1;
            prevAcc   <= lastAcc;
            lastAcc   <= cycle;
        end
    end

    logic [5:1]  rdenAt;
    logic [5:1]  wrenAt;
    logic [5:1]  respAt;
    logic [15:0] addrAt [1:5];
    logic [31:0] dataAt [1:5];

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        tbWr = 1'b1; tbAddr = a; tbData = d;
        @(negedge clk);
        tbWr = 1'b0;
    endtask

    // Present one request, wait (bounded) for the accept edge, then scramble inputs.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW+1:0] a, input logic [31:0] wd);
        int budget;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) check("accept_timeout", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_size = 2'b11; req_signed = ~sg;
        req_addr = '1; req_wdata = 32'h0BAD0BAD;
    endtask

    // Record cycles T+1..T+5 after the accept edge.
    task automatic capture();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rdenAt[k] = memAccessRden;
            wrenAt[k] = memAccessWren;
            respAt[k] = resp_valid;
            addrAt[k] = memAccessAddress;
            dataAt[k] = memAccessData;
        end
    endtask

    task automatic loadTest(input string name, input logic [1:0] sz, input logic sg,
                            input logic [AW+1:0] a, input logic [31:0] exp);
        expQ.push_back('{rdata: exp, mis: 1'b0});
        issue(1'b0, sz, sg, a, 32'h0);
        capture();
        check({name, "_rden_t1"}, {31'b0, rdenAt[1]}, 32'h1);
        check({name, "_addr_t1"}, {16'b0, addrAt[1]}, {16'b0, a[17:2]});
        check({name, "_resp_t3"}, {29'b0, respAt[3:1]}, 32'h4);
        check({name, "_no_wren"}, {27'b0, wrenAt}, 32'h0);
        check({name, "_rdata_hold"}, resp_rdata, exp);
    endtask

    initial begin
        int wrenSeen;
        int startCnt;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        #2;
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_addr", {16'b0, memAccessAddress}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);

        // Word store: WRITE at T+1, response at T+2, no read.
        expQ.push_back('{rdata: 32'h0, mis: 1'b0});
        issue(1'b1, 2'b10, 1'b0, 18'h0010, 32'hDEADBEEF);
        capture();
        check("wst_wren_t1", {31'b0, wrenAt[1]}, 32'h1);
        check("wst_addr_t1", {16'b0, addrAt[1]}, 32'h4);
        check("wst_data_t1", dataAt[1], 32'hDEADBEEF);
        check("wst_resp_t2", {30'b0, respAt[2:1]}, 32'h2);
        check("wst_no_rden", {27'b0, rdenAt}, 32'h0);
        check("wst_addr_hold", {16'b0, addrAt[2]}, 32'h4);
        check("wst_data_idle", dataAt[2], 32'h0);
        check("wst_mem", mem[4], 32'hDEADBEEF);

        preload(8'd4, 32'h80FF1234);
        preload(8'd8, 32'h11223344);
        preload(8'd12, 32'hCAFEF00D);

        loadTest("lb_s", 2'b00, 1'b1, 18'h0013, 32'hFFFFFF80);
        loadTest("lb_u", 2'b00, 1'b0, 18'h0013, 32'h00000080);
        loadTest("lh_s", 2'b01, 1'b1, 18'h0012, 32'hFFFF80FF);
        loadTest("lb_u0", 2'b00, 1'b0, 18'h0010, 32'h00000034);
        loadTest("lw", 2'b10, 1'b1, 18'h0010, 32'h80FF1234);

        // Errors: immediate response, no memory cycles, rdata cleared.
        expQ.push_back('{rdata: 32'h0, mis: 1'b1});
        issue(1'b0, 2'b10, 1'b0, 18'h0006, 32'h0);
        capture();
        check("mis_w_resp_t1", {31'b0, respAt[1]}, 32'h1);
        check("mis_w_no_strobes", {27'b0, rdenAt | wrenAt}, 32'h0);

        expQ.push_back('{rdata: 32'h0, mis: 1'b1});
        issue(1'b1, 2'b11, 1'b0, 18'h0000, 32'h12345678);
        capture();
        check("mis_sz_resp_t1", {31'b0, respAt[1]}, 32'h1);
        check("mis_sz_no_strobes", {27'b0, rdenAt | wrenAt}, 32'h0);

        expQ.push_back('{rdata: 32'h0, mis: 1'b1});
        issue(1'b0, 2'b01, 1'b0, 18'h0011, 32'h0);
        capture();
        check("mis_h_resp_t1", {31'b0, respAt[1]}, 32'h1);

        // Half store read-modify-write.
        expQ.push_back('{rdata: 32'h0, mis: 1'b0});
        issue(1'b1, 2'b01, 1'b0, 18'h0022, 32'hFFFFABCD);
        capture();
        check("sh_rden_t1", {31'b0, rdenAt[1]}, 32'h1);
        check("sh_addr_t1", {16'b0, addrAt[1]}, 32'h8);
        check("sh_data_t1", dataAt[1], 32'h0);
        check("sh_wren", {27'b0, wrenAt}, 32'h4);
        check("sh_data_t3", dataAt[3], 32'hABCD3344);
        check("sh_resp_t4", {28'b0, respAt[4:1]}, 32'h8);

        // Byte store into lane 1 of the merged word.
        expQ.push_back('{rdata: 32'h0, mis: 1'b0});
        issue(1'b1, 2'b00, 1'b1, 18'h0021, 32'h1234565A);
        capture();
        check("sb_data_t3", dataAt[3], 32'hABCD5A44);
        check("sb_mem", mem[8], 32'hABCD5A44);
        check("sb_rdata_zero", resp_rdata, 32'h0);

        // Reset during WAIT of a byte store.
        issue(1'b1, 2'b00, 1'b0, 18'h0030, 32'h00000077);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_busy_wait", {31'b0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_rden", {31'b0, memAccessRden}, 32'h0);
        check("rstmid_wren", {31'b0, memAccessWren}, 32'h0);
        check("rstmid_ready", {31'b0, req_ready}, 32'h0);
        check("rstmid_busy", {31'b0, busy}, 32'h0);
        wrenSeen = 0;
        repeat (2) begin
            @(negedge clk);
            wrenSeen += int'(memAccessWren);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrel_ready", {31'b0, req_ready}, 32'h1);
        check("rstrel_busy", {31'b0, busy}, 32'h0);
        repeat (4) begin
            @(negedge clk);
            wrenSeen += int'(memAccessWren);
        end
        check("rstmid_no_wren", wrenSeen, 32'h0);
        check("rstmid_mem", mem[12], 32'hCAFEF00D);

        // Back-to-back word stores with req_valid held high.
        @(negedge clk);
        for (int i = 0; i < 3; i++) expQ.push_back('{rdata: 32'h0, mis: 1'b0});
        startCnt = acceptCnt;
        req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 18'h0040; req_wdata = 32'h11111111;
        req_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_accepts", acceptCnt - startCnt, 32'h3);
        check("b2b_gap", lastAcc - prevAcc, 32'h3);
        check("b2b_mem", mem[16], 32'h11111111);

        check("queue_empty", expQ.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator for the data port of operational memory (memAccessAddress/Wren/Data/Rden, memAccessOutput).
- Accepts byte, halfword and word load/store requests from the core pipeline over a valid/ready handshake, using byte addresses.
- Translates each request into word-granular memory cycles; sub-word stores use read-modify-write because the memory has no byte enables.
- Returns one response per request, with extended load data or a misalignment error.

Parameters:
- ADDR_WIDTH, 16, word-address width of the memory port; the request byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, memory word width; the byte-lane logic below is fixed for 32.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data.
- resp_misaligned  out  1  error flag, qualified by resp_valid.
- busy  out  1  state != IDLE.
- memAccessAddress  out  ADDR_WIDTH  word address = latched req_addr[ADDR_WIDTH+1:2].
- memAccessWren  out  1  write strobe.
- memAccessData  out  32  write word.
- memAccessRden  out  1  read strobe.
- memAccessOutput  in  32  read data, valid the cycle after Rden.

Behaviour:
- Reset: asynchronous, sets state to IDLE. While reset is asserted all outputs are 0 except req_ready, which is 0 during reset and 1 in IDLE after release.
- Strobes: decoded from state only. Reset mid-operation therefore drops them immediately, and no write is issued for an interrupted read-modify-write.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
- IDLE, accept on req_valid && req_ready: latch write, size, signed, addr and wdata.
  - Misaligned or illegal request goes to RESP with the error flag set. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Word store goes to WRITE.
  - Load or sub-word store goes to READ.
- READ: memAccessRden=1; go to WAIT.
- WAIT: memAccessOutput is sampled.
  - Load: register the extracted and extended value into resp_rdata; go to RESP.
  - Sub-word store: register the merged word; go to WRITE.
- WRITE: memAccessWren=1 and memAccessData = merged word, or req_wdata for a word store; go to RESP.
- RESP: resp_valid=1 for exactly one cycle; go to IDLE.
- Strobes and data outside their states: Rden=0 and Wren=0 outside READ/WRITE. memAccessData=0 outside WRITE. memAccessAddress holds the latched word address.
- Latency, counted from the accept cycle T to resp_valid:
  - misaligned T+1.
  - word store T+2.
  - load T+3.
  - sub-word store T+4.
- Byte lanes: little-endian. Byte lane = addr[1:0], occupying bits [8*lane+7 : 8*lane]. Half lane = addr[1], occupying bits [16*addr[1]+15 : 16*addr[1]].
- Sub-word load extension: zero-extend, or sign-extend when req_signed=1. Word loads ignore req_signed.
- Merge: the store replaces only the addressed lane(s) with the low byte/half of wdata; other lanes keep the read value.
- resp_rdata:
  - 0 for stores and errors.
  - For loads, holds its value until the next response.
  - resp_misaligned is 0 on every non-error response.
- Handshake:
  - req_valid outside IDLE is ignored; no queueing.
  - After RESP, the next accept occurs no earlier than the following cycle.
  - req_* inputs may change freely after the accept cycle.
- operationMode is owned outside this block and must stay stable while busy=1.

Test Plan:
- Word store 0xDEADBEEF at byte address 0x0010 -> at T+1 Wren=1, memAccessAddress=0x0004, memAccessData=0xDEADBEEF; resp_valid at T+2, resp_misaligned=0, Rden never high.
- Signed byte load at 0x0013, memory word 0x80FF1234 -> Rden at T+1 with address 0x0004; resp_rdata=0xFFFFFF80 at T+3. Repeat unsigned -> 0x00000080.
- Half store 0xABCD at 0x0022 over word 0x11223344 -> Rden at T+1, Wren at T+3 with data 0xABCD3344 at address 0x0008; resp_valid at T+4.
- Word load at 0x0006 and a size=11 request -> no Rden/Wren ever; resp_valid at T+1, resp_misaligned=1, resp_rdata=0.
- rst_n low while in WAIT of a byte store -> strobes 0 in the same cycle, no Wren ever, no resp_valid. After release, req_ready=1 and busy=0.
- req_valid held high with back-to-back requests -> exactly one accept per transaction. Requests presented while busy=1 are not accepted. Second accept occurs the cycle after resp_valid.
